// File: rtl/simple_processor_pkg.sv
// -----------------------------------------------------------------------------
// simple_processor_pkg
//   Shared types and helpers for the simple_processor memory bus.
//   - mem_rsp_state_e : state encoding of the memory-side responder FSM
//   - mem_word_index  : byte address -> word index, relative to a base address
// -----------------------------------------------------------------------------
package simple_processor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_rsp_state_e;

    // Word index of a byte address. The subtraction wraps at addr_width bits,
    // so addresses below the base land far out of range instead of aliasing
    // onto low words. Low byte-offset bits are discarded by the final shift.
    function automatic logic [63:0] mem_word_index(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned addr_width,
        input int unsigned byte_shift
    );
        logic [63:0] off;
        logic [63:0] mask;
        off = addr - base;
        if (addr_width >= 32'd64) begin
            mask = '1;
        end else begin
            mask = (64'd1 << addr_width) - 64'd1;
        end
        off = off & mask;
        return off >> byte_shift;
    endfunction

endpackage

// File: rtl/simple_mem_responder_checker.sv
// -----------------------------------------------------------------------------
// simple_mem_responder_checker
//   Simulation-only property checks for simple_mem_responder. Bind or
//   instantiate next to the responder with the same parameter values.
//   Ports:
//     clk_i    responder clock
//     arst_ni  responder asynchronous active-low reset
//     ack      responder ack_o
// -----------------------------------------------------------------------------
module simple_mem_responder_checker #(
    parameter int LATENCY        = 2,
    parameter int DEPTH          = 1024,
    parameter int MEM_DATA_WIDTH = 32
) (
    input logic clk_i,
    input logic arst_ni,
    input logic ack
);

    // Parameter legality, re-evaluated every clock so a bad build fails early
    a_latency_min : assert property (@(posedge clk_i) LATENCY >= 32'sd1);
    a_depth_pow2  : assert property (@(posedge clk_i) (DEPTH & (DEPTH - 32'sd1)) == 32'sd0);
    a_width_bytes : assert property (@(posedge clk_i) (MEM_DATA_WIDTH % 32'sd8) == 32'sd0);

    // An ack is always a single-cycle pulse
    a_ack_pulse   : assert property (@(posedge clk_i) disable iff (!arst_ni) ack |=> !ack);

endmodule

// File: rtl/simple_mem_responder.sv
// -----------------------------------------------------------------------------
// simple_mem_responder
//   Memory-side responder for the simple_processor req/ack bus. One access is
//   in flight at a time; each completes with a one-cycle ack LATENCY cycles
//   after acceptance. Backing store is a word-organised array (mem) that is
//   not reset and is reachable hierarchically for preload/inspection.
//   Ports:
//     clk_i    clock
//     arst_ni  asynchronous active-low reset
//     req_i    request strobe (accepted only in IDLE)
//     wr_i     1 = write, 0 = read (captured at acceptance)
//     addr_i   byte address (captured at acceptance)
//     wdata_i  write data (captured at acceptance)
//     rdata_o  read data, non-zero only while ack_o is high
//     ack_o    one-cycle completion pulse
// -----------------------------------------------------------------------------
module simple_mem_responder
    import simple_processor_pkg::*;
#(
    parameter int                        MEM_ADDR_WIDTH = 32,
    parameter int                        MEM_DATA_WIDTH = 32,
    parameter int                        DEPTH          = 1024,
    parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        LATENCY        = 2
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      req_i,
    input  logic                      wr_i,
    input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
    input  logic [MEM_DATA_WIDTH-1:0] wdata_i,
    output logic [MEM_DATA_WIDTH-1:0] rdata_o,
    output logic                      ack_o
);

    localparam int BYTE_SHIFT = $clog2(MEM_DATA_WIDTH / 8);
    localparam int IDX_W      = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(LATENCY + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Backing store; intentionally without reset
    logic [DEPTH-1:0][MEM_DATA_WIDTH-1:0] mem;

    mem_rsp_state_e              state_r;
    logic [CNT_W-1:0]            cnt_r;
    logic                        cap_wr_r;
    logic                        cap_hit_r;
    logic [IDX_W-1:0]            cap_idx_r;
    logic [MEM_DATA_WIDTH-1:0]   cap_wdata_r;
    logic                        ack_r;
    logic [MEM_DATA_WIDTH-1:0]   rdata_r;

    logic [63:0]                 in_word_s;
    logic                        in_hit_s;
    logic [IDX_W-1:0]            in_idx_s;
    logic [MEM_DATA_WIDTH-1:0]   in_rd_word_s;
    logic [MEM_DATA_WIDTH-1:0]   cap_rd_word_s;

    // Decode the live address (used when LATENCY=1 jumps straight to RESP)
    // and read both candidate words; the FSM picks the one it needs.
    always_comb begin
        in_word_s     = mem_word_index(64'(addr_i), 64'(BASE_ADDR),
                                       MEM_ADDR_WIDTH, BYTE_SHIFT);
        in_hit_s      = (in_word_s < 64'(DEPTH));
        in_idx_s      = in_word_s[IDX_W-1:0];
        in_rd_word_s  = mem[in_idx_s];
        cap_rd_word_s = mem[cap_idx_r];
    end

    // Request FSM with registered ack/rdata. Outputs are loaded on the edge
    // that enters RESP so they are valid for exactly the RESP cycle.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            cap_wr_r    <= 1'b0;
            cap_hit_r   <= 1'b0;
            cap_idx_r   <= '0;
            cap_wdata_r <= '0;
            ack_r       <= 1'b0;
            rdata_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r   <= 1'b0;
                    rdata_r <= '0;
                    if (req_i) begin
                        cap_wr_r    <= wr_i;
                        cap_hit_r   <= in_hit_s;
                        cap_idx_r   <= in_idx_s;
                        cap_wdata_r <= wdata_i;
                        cnt_r       <= CNT_LOAD;
                        if (LATENCY == 32'sd1) begin
                            state_r <= RESP;
                            ack_r   <= 1'b1;
                            rdata_r <= (!wr_i && in_hit_s) ? in_rd_word_s : '0;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Moving to RESP when the counter would hit zero puts the
                    // ack in the LATENCY-th cycle after acceptance.
                    if (cnt_r == CNT_ONE) begin
                        cnt_r   <= '0;
                        state_r <= RESP;
                        ack_r   <= 1'b1;
                        rdata_r <= (!cap_wr_r && cap_hit_r) ? cap_rd_word_s : '0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    ack_r   <= 1'b0;
                    rdata_r <= '0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    ack_r   <= 1'b0;
                    rdata_r <= '0;
                end
            endcase
        end
    end

    // Commit an in-range write on the edge leaving RESP. A reset during the
    // access forces IDLE asynchronously, so a pending write never lands.
    always_ff @(posedge clk_i) begin
        if (state_r == RESP && cap_wr_r && cap_hit_r) begin
            mem[cap_idx_r] <= cap_wdata_r;
        end
    end

    assign ack_o   = ack_r;
    assign rdata_o = rdata_r;

endmodule

// File: tb/tb_simple_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_simple_mem_responder
//   Three responders share one clock: LATENCY 2 (main table + random run
//   against a word-array reference model), LATENCY 1 (back-to-back) and
//   LATENCY 4 (reset while waiting).
// -----------------------------------------------------------------------------
module tb_simple_mem_responder;

    logic              clk;
    logic [2:0]        rst_n;
    logic [2:0]        req;
    logic [2:0]        wr;
    logic [2:0][31:0]  addr;
    logic [2:0][31:0]  wdata;
    wire  [2:0][31:0]  rdata;
    wire  [2:0]        ack;

    int n_tests = 0;
    int n_fail  = 0;

    int lat_of [3] = '{2, 1, 4};

    // reference model for DUT 0: sparse word store, absent = never written
    logic [31:0] model [int];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    simple_mem_responder #(.LATENCY(2)) dut0 (
        .clk_i(clk), .arst_ni(rst_n[0]), .req_i(req[0]), .wr_i(wr[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]));
    simple_mem_responder #(.LATENCY(1)) dut1 (
        .clk_i(clk), .arst_ni(rst_n[1]), .req_i(req[1]), .wr_i(wr[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]));
    simple_mem_responder #(.LATENCY(4)) dut2 (
        .clk_i(clk), .arst_ni(rst_n[2]), .req_i(req[2]), .wr_i(wr[2]),
        .addr_i(addr[2]), .wdata_i(wdata[2]), .rdata_o(rdata[2]), .ack_o(ack[2]));

    simple_mem_responder_checker #(.LATENCY(2)) chk0 (.clk_i(clk), .arst_ni(rst_n[0]), .ack(ack[0]));
    simple_mem_responder_checker #(.LATENCY(1)) chk1 (.clk_i(clk), .arst_ni(rst_n[1]), .ack(ack[1]));
    simple_mem_responder_checker #(.LATENCY(4)) chk2 (.clk_i(clk), .arst_ni(rst_n[2]), .ack(ack[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete bus access: request for one edge, then wait (bounded) for
    // the ack, check its latency and data, then check the output returns idle.
    task automatic do_access(input int d, input bit w, input logic [31:0] a,
                             input logic [31:0] wd, input bit chk_data,
                             input logic [31:0] exp_rd, input string nm);
        int cyc;
        bit seen;
        @(negedge clk);
        req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 16) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) req[d] = 1'b0;
            if (ack[d] === 1'b1) seen = 1'b1;
        end
        check({nm, " latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(lat_of[d]));
        if (seen && (w || chk_data))
            check({nm, " rdata"}, rdata[d], w ? 32'h0 : exp_rd);
        @(posedge clk); #1;
        check({nm, " idle after ack"}, {ack[d], rdata[d][30:0]}, 32'h0);
        if (rdata[d][31] !== 1'b0) check({nm, " rdata msb after ack"}, {31'h0, rdata[d][31]}, 32'h0);
    endtask

    // Model access for DUT 0 from the decode rules: wrapping offset, word
    // index = offset/4, in range iff index < 1024.
    task automatic model_access(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                output bit known, output logic [31:0] exp_rd);
        logic [31:0] off;
        int          idx;
        bit          in_rng;
        off    = a - 32'h0;
        in_rng = (off / 4) < 1024;
        idx    = int'(off / 4);
        known  = 1'b1;
        exp_rd = 32'h0;
        if (w) begin
            if (in_rng) model[idx] = wd;
        end else if (in_rng) begin
            if (model.exists(idx)) exp_rd = model[idx];
            else known = 1'b0;
        end
    endtask

    initial begin
        bit          known;
        logic [31:0] exp_rd;
        logic [31:0] b2b [3];
        int          k;

        rst_n = 3'b111; req = '0; wr = '0; addr = '0; wdata = '0;
        #1 rst_n = 3'b000;

        // 1. Reset held: requests are ignored, outputs stay low
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req = ~req; wr = 3'b000; addr = {3{32'h10}};
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++)
                check($sformatf("reset dut%0d cyc%0d", d, c), {ack[d], rdata[d][30:0]}, 32'h0);
        end
        @(negedge clk);
        req = '0;
        rst_n = 3'b111;

        // 2-4. Directed vectors on LATENCY=2
        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0};
        tbl[3]  = '{1'b0, 32'h0000_0023, 32'h0,         32'h1234_5678};
        tbl[4]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0};
        tbl[5]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0};
        tbl[6]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0};
        tbl[7]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5};
        tbl[8]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0};
        tbl[9]  = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 32'h0};
        tbl[10] = '{1'b0, 32'h0000_0FFF, 32'h0,         32'h0BAD_F00D};
        tbl[11] = '{1'b0, 32'h0000_1003, 32'h0,         32'h0};
        for (int i = 0; i < 12; i++) begin
            model_access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, known, exp_rd);
            do_access(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i].exp,
                      $sformatf("vec%0d", i));
        end

        // Randomized traffic on LATENCY=2 against the reference model
        for (int i = 0; i < 150; i++) begin
            bit          w;
            logic [31:0] a;
            logic [31:0] wd;
            w  = 1'($urandom_range(0, 1));
            wd = $urandom();
            if ($urandom_range(0, 4) == 0) a = $urandom();
            else a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            model_access(w, a, wd, known, exp_rd);
            do_access(0, w, a, wd, known, exp_rd, $sformatf("rnd%0d", i));
        end

        // 5. Back-to-back reads with req held high, LATENCY=1
        b2b[0] = 32'hAAAA_0001; b2b[1] = 32'hBBBB_0002; b2b[2] = 32'hCCCC_0003;
        for (int i = 0; i < 3; i++)
            do_access(1, 1'b1, 32'(4 * (i + 1)), b2b[i], 1'b0, 32'h0, $sformatf("b2b pre%0d", i));
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h4;
        k = 0;
        for (int c = 1; c <= 6; c++) begin
            bit exp_ack;
            @(posedge clk); #1;
            exp_ack = (c % 2) == 1;
            check($sformatf("b2b ack c%0d", c), {31'h0, ack[1]}, {31'h0, exp_ack});
            check($sformatf("b2b rdata c%0d", c), rdata[1], exp_ack ? b2b[k] : 32'h0);
            if (exp_ack) begin
                k++;
                if (k < 3) addr[1] = 32'(4 * (k + 1));
                else req[1] = 1'b0;
            end
        end

        // 6. Reset during WAIT, LATENCY=4: write must vanish, no ack
        do_access(2, 1'b1, 32'h40, 32'h1111_2222, 1'b0, 32'h0, "rst pre");
        @(negedge clk);
        req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'h9999_8888;
        @(posedge clk); #1;
        req[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) rst_n[2] = 1'b1;
            check($sformatf("rst no ack c%0d", c), {31'h0, ack[2]}, 32'h0);
        end
        do_access(2, 1'b0, 32'h40, 32'h0, 1'b1, 32'h1111_2222, "rst readback");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
